// File: rtl/ftoi_issue_sched_pkg.sv
// Shared FPU constants for the float-to-int issue scheduler.
// Holds the conversion-unit latency and the requester id width helper.
package ftoi_issue_sched_pkg;

  localparam int FTOI_LAT = 1;
  localparam int FTOI_DW  = 32;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ftoi_result_fifo.sv
// Result FIFO for the float-to-int scheduler.
// Power-of-two depth; the count tells full from empty.
module ftoi_result_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [W-1:0]               i_wdata,
  input  logic                       i_pop,
  output logic [W-1:0]               o_rdata,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wp] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) begin
        r_wp <= r_wp + AW'(1);
      end
      if (i_pop) begin
        r_rp <= r_rp + AW'(1);
      end
      unique case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_rdata = o_empty ? '0 : r_mem[r_rp];

endmodule

// File: rtl/ftoi_issue_sched.sv
// Round-robin issue scheduler sharing one pipelined float-to-int unit.
// Tracks in-flight ids and returns tagged results through a credited FIFO.
module ftoi_issue_sched
  import ftoi_issue_sched_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int LAT   = FTOI_LAT,
  parameter int DEPTH = 4,
  parameter int IDW   = id_width(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*32-1:0]     req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic [FTOI_DW-1:0]     conv_s,
  input  logic [FTOI_DW-1:0]     conv_d,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [IDW-1:0]         resp_id,
  output logic [FTOI_DW-1:0]     resp_data
);

  localparam int CW = $clog2(DEPTH+1);

  logic [IDW-1:0] r_rr;
  logic [LAT-1:0] r_pv;
  logic [IDW-1:0] r_pid [LAT];

  logic                   w_found;
  logic [IDW-1:0]         w_gid;
  logic                   w_can;
  int                     w_occ;
  logic [CW-1:0]          w_cnt;
  logic                   w_empty;
  logic                   w_pop;
  logic [IDW+FTOI_DW-1:0] w_head;

  always_comb begin
    w_occ = 0;
    for (int i = 0; i < LAT; i++) begin
      w_occ = w_occ + int'(r_pv[i]);
    end
  end

  // A pop in this same cycle is not credited, so DEPTH == LAT+1 cannot stream.
  assign w_can = !rst && ((w_occ + int'(w_cnt)) < DEPTH);

  always_comb begin
    w_found   = 1'b0;
    w_gid     = '0;
    req_ready = '0;
    conv_s    = '0;
    if (w_can) begin
      for (int k = 0; k < NREQ; k++) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!w_found && req_valid[i] &&
              ((int'(r_rr) + k) % NREQ == i)) begin
            w_found      = 1'b1;
            w_gid        = IDW'(i);
            req_ready[i] = 1'b1;
            conv_s       = req_data[32*i +: 32];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr <= '0;
      r_pv <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_pid[i] <= '0;
      end
    end else begin
      if (w_found) begin
        r_rr <= (w_gid == IDW'(NREQ-1)) ? '0 : w_gid + IDW'(1);
      end
      r_pv[0]  <= w_found;
      r_pid[0] <= w_gid;
      for (int i = 1; i < LAT; i++) begin
        r_pv[i]  <= r_pv[i-1];
        r_pid[i] <= r_pid[i-1];
      end
    end
  end

  assign w_pop = !w_empty && resp_ready;

  ftoi_result_fifo #(
    .W     (IDW + FTOI_DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_pv[LAT-1]),
    .i_wdata ({r_pid[LAT-1], conv_d}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_count (w_cnt)
  );

  assign resp_valid = !w_empty;
  assign resp_id    = w_head[IDW+FTOI_DW-1:FTOI_DW];
  assign resp_data  = w_head[FTOI_DW-1:0];

endmodule

// File: tb/tb_ftoi_issue_sched.sv
// Scoreboard bench for ftoi_issue_sched with a table-driven conversion unit.
// Grants and responses are checked cycle by cycle against a reference model.
module tb_ftoi_issue_sched;

  localparam int NREQ  = 2;
  localparam int LAT   = 1;
  localparam int DEPTH = 4;
  localparam int IDW   = 1;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [31:0]        conv_s;
  logic [31:0]        conv_d;
  logic               resp_valid;
  logic               resp_ready;
  logic [IDW-1:0]     resp_id;
  logic [31:0]        resp_data;

  ftoi_issue_sched #(
    .NREQ  (NREQ),
    .LAT   (LAT),
    .DEPTH (DEPTH),
    .IDW   (IDW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .conv_s     (conv_s),
    .conv_d     (conv_d),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed conversion results for every operand the bench issues.
  function automatic logic [31:0] lut(input logic [31:0] s);
    case (s)
      32'h3FC00000: return 32'h00000002;
      32'hC0200000: return 32'hFFFFFFFD;
      32'h3ECCCCCD: return 32'h00000000;
      32'h4F32D05E: return 32'h80000000;
      32'h3F800000: return 32'h00000001;
      32'h40000000: return 32'h00000002;
      32'h40400000: return 32'h00000003;
      32'h40800000: return 32'h00000004;
      32'h40A00000: return 32'h00000005;
      32'hBF800000: return 32'hFFFFFFFF;
      32'h00000000: return 32'h00000000;
      default:      return ~s;
    endcase
  endfunction

  always @(posedge clk) conv_d <= lut(conv_s);

  typedef struct {
    int          id;
    logic [31:0] d;
    int          at;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int m_rr   = 0;
  int m_out  = 0;
  int gcount = 0;

  always @(posedge clk) cyc = cyc + 1;

  // Monitor: reference arbiter, credit and result queue.
  always @(negedge clk) begin
    logic [NREQ-1:0] egnt;
    logic [31:0]     edata;
    logic            exp_rv;
    int              eid;
    bit              found;
    exp_t            e;
    egnt  = '0;
    edata = '0;
    eid   = 0;
    found = 0;
    if (rst) begin
      checks++;
      if (req_ready !== '0 || resp_valid !== 1'b0 ||
          resp_id !== '0 || resp_data !== '0) begin
        fails++;
        $display("FAIL reset_outputs: rdy=%b rv=%b id=%0d d=%h, required 0/0/0/0",
                 req_ready, resp_valid, resp_id, resp_data);
      end
      sb.delete();
      m_rr  = 0;
      m_out = 0;
    end else begin
      if (m_out < DEPTH) begin
        for (int k = 0; k < NREQ; k++) begin
          int idx;
          idx = (m_rr + k) % NREQ;
          if (!found && req_valid[idx]) begin
            found = 1;
            eid   = idx;
          end
        end
      end
      if (found) begin
        egnt[eid] = 1'b1;
        edata     = req_data[32*eid +: 32];
      end
      checks++;
      if (req_ready !== egnt) begin
        fails++;
        $display("FAIL grant @%0d: got %b, required %b", cyc, req_ready, egnt);
      end
      checks++;
      if (conv_s !== edata) begin
        fails++;
        $display("FAIL conv_s @%0d: got %h, required %h", cyc, conv_s, edata);
      end
      if (found) begin
        e.id = eid;
        e.d  = lut(edata);
        e.at = cyc + LAT + 1;
        sb.push_back(e);
        if (eid == 0) void'(q0.pop_front());
        else          void'(q1.pop_front());
        m_rr = (eid + 1) % NREQ;
        gcount++;
      end
      exp_rv = (sb.size() > 0) && (sb[0].at <= cyc);
      checks++;
      if (resp_valid !== exp_rv) begin
        fails++;
        $display("FAIL resp_valid @%0d: got %b, required %b", cyc, resp_valid, exp_rv);
      end
      if (exp_rv && resp_ready) begin
        e = sb.pop_front();
        checks++;
        if (int'(resp_id) != e.id || resp_data !== e.d) begin
          fails++;
          $display("FAIL resp @%0d: got id=%0d d=%h, required id=%0d d=%h",
                   cyc, resp_id, resp_data, e.id, e.d);
        end
        m_out--;
      end
      if (!exp_rv) begin
        checks++;
        if (resp_id !== '0 || resp_data !== '0) begin
          fails++;
          $display("FAIL empty_head @%0d: got id=%0d d=%h, required 0/0",
                   cyc, resp_id, resp_data);
        end
      end
      if (found) m_out++;
    end
  end

  task automatic refresh();
    req_valid[0]     = (q0.size() > 0);
    req_valid[1]     = (q1.size() > 0);
    req_data[31:0]   = (q0.size() > 0) ? q0[0] : 32'h0;
    req_data[63:32]  = (q1.size() > 0) ? q1[0] : 32'h0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      refresh();
    end
  endtask

  task automatic drain(input string name, input int bound);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0) && n < bound) begin
      tick(1);
      n++;
    end
    checks++;
    if (n >= bound) begin
      fails++;
      $display("FAIL %s drain: got %0d/%0d/%0d left after %0d cycles, required 0",
               name, q0.size(), q1.size(), sb.size(), n);
    end
  endtask

  task automatic check_gcount(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      fails++;
      $display("FAIL %s grants: got %0d, required %0d", name, got, req);
    end
  endtask

  initial begin
    logic [31:0] ops [4];
    int g0;
    ops[0] = 32'h3F800000;
    ops[1] = 32'h40000000;
    ops[2] = 32'h40400000;
    ops[3] = 32'h40800000;
    rst        = 1'b1;
    resp_ready = 1'b1;
    req_valid  = '0;
    req_data   = '0;

    // Contention held from reset: req0 then req1.
    q0.push_back(32'hC0200000);
    q1.push_back(32'h3ECCCCCD);
    refresh();
    tick(3);
    rst = 1'b0;
    g0  = gcount;
    tick(2);
    check_gcount("contention", gcount - g0, 2);
    drain("contention", 20);

    // Single request on req0.
    q0.push_back(32'h3FC00000);
    refresh();
    drain("single", 20);

    // Fairness: both valid for 20 cycles.
    for (int i = 0; i < 10; i++) begin
      q0.push_back(ops[i % 4]);
      q1.push_back(ops[(i + 2) % 4]);
    end
    refresh();
    g0 = gcount;
    tick(20);
    check_gcount("fairness", gcount - g0, 20);
    drain("fairness", 30);

    // Backpressure: exactly DEPTH grants, then stall.
    resp_ready = 1'b0;
    repeat (6) q0.push_back(32'h4F32D05E);
    refresh();
    g0 = gcount;
    tick(8);
    check_gcount("backpressure", gcount - g0, 4);
    resp_ready = 1'b1;
    drain("backpressure", 30);

    // Full occupancy then streaming push/pop.
    resp_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      q0.push_back((i % 3 == 0) ? 32'h00000000 :
                   (i % 3 == 1) ? 32'hBF800000 : 32'h40A00000);
    end
    refresh();
    tick(6);
    resp_ready = 1'b1;
    drain("full_stream", 40);

    // Irregular consumer.
    for (int i = 0; i < 6; i++) begin
      q0.push_back(ops[i % 4]);
      q1.push_back(ops[(i + 1) % 4]);
    end
    refresh();
    for (int i = 0; i < 40 && (q0.size() + q1.size() + sb.size()) > 0; i++) begin
      resp_ready = (i % 3 != 0);
      tick(1);
    end
    resp_ready = 1'b1;
    drain("irregular", 30);

    // Leave rr pointing at req0 before the reset test.
    q1.push_back(32'h3FC00000);
    refresh();
    drain("single1", 20);

    // Reset mid-flight with results queued.
    resp_ready = 1'b0;
    q0.push_back(32'h3F800000);
    q0.push_back(32'h40000000);
    q0.push_back(32'h40400000);
    q1.push_back(32'h40800000);
    q1.push_back(32'h3FC00000);
    q1.push_back(32'hC0200000);
    refresh();
    tick(3);
    rst = 1'b1;
    tick(2);
    rst        = 1'b0;
    resp_ready = 1'b1;
    refresh();
    g0 = gcount;
    tick(1);
    check_gcount("post_reset", gcount - g0, 1);
    drain("post_reset", 30);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
